// File: rtl/regfile_2r1w.sv
// 16x32 register file: two combinational read ports, one synchronous write port addressed by address_a.
// Optional macro REGFILE_BYPASS_EN forwards write_data to matching read ports in the write cycle.
module regfile_2r1w #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ZERO_REG0  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] data_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_allowed;

  // Register 0 is write-protected when hardwired to zero.
  assign wr_allowed = write_enable &&
                      !((ZERO_REG0 != 0) && (address_a == ADDR_WIDTH'(0)));

  always_comb begin
    regs_d = regs_q;
    if (wr_allowed) begin
      regs_d[address_a] = write_data;
    end
  end

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    data_a = regs_q[address_a];
    data_b = regs_q[address_b];
`ifdef REGFILE_BYPASS_EN
    if (write_enable && rst_n) begin
      data_a = write_data;
      if (address_b == address_a) begin
        data_b = write_data;
      end
    end
`endif
    if ((ZERO_REG0 != 0) && (address_a == ADDR_WIDTH'(0))) begin
      data_a = '0;
    end
    if ((ZERO_REG0 != 0) && (address_b == ADDR_WIDTH'(0))) begin
      data_b = '0;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed vectors, corner sequences and a randomized run
// against an array-based reference model.
module tb_regfile_2r1w;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned ZR = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic          we;
  logic [DW-1:0] wd;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;

  regfile_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG0(ZR)) dut (
    .clk(clk), .rst_n(rst_n), .address_a(addr_a), .address_b(addr_b),
    .write_enable(we), .write_data(wd), .data_a(data_a), .data_b(data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [DW-1:0] w;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: array state updated from the rules, applied at the coming edge.
  task automatic tick();
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) mem[k] = '0;
    end else if (we && !(ZR != 0 && addr_a == 4'd0)) begin
      mem[addr_a] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] addr);
    if (ZR != 0 && addr == 4'd0) return '0;
    if (BYP && we && rst_n && addr == addr_a) return wd;
    return mem[addr];
  endfunction

  initial begin
    vecs[0] = '{1'b1, 4'd3, 4'd3, 32'h0000ABCD, 32'h0000ABCD, 32'h0000ABCD};
    vecs[1] = '{1'b0, 4'd3, 4'd4, 32'h00000000, 32'h0000ABCD, 32'h00000000};
    vecs[2] = '{1'b0, 4'd7, 4'd3, 32'hFFFFFFFF, 32'h00000000, 32'h0000ABCD};
    vecs[3] = '{1'b1, 4'd1, 4'd3, 32'h00000005, 32'h00000005, 32'h0000ABCD};
    vecs[4] = '{1'b1, 4'd2, 4'd1, 32'h00000001, 32'h00000001, 32'h00000005};
    vecs[5] = '{1'b1, 4'd2, 4'd1, 32'h00000002, 32'h00000002, 32'h00000005};
    vecs[6] = '{1'b0, 4'd2, 4'd2, 32'h00000000, 32'h00000002, 32'h00000002};
    vecs[7] = '{1'b1, 4'd0, 4'd0, 32'hCAFEF00D,
                (ZR != 0) ? 32'h0 : 32'hCAFEF00D, (ZR != 0) ? 32'h0 : 32'hCAFEF00D};

    rst_n = 1'b0; we = 1'b0; addr_a = '0; addr_b = '0; wd = '0;
    #2;
    tick();
    rst_n = 1'b1;
    addr_a = 4'd0; addr_b = 4'd15; #1;
    check("reset_a_r0", data_a, 32'h0);
    check("reset_b_r15", data_b, 32'h0);

    // Reset beats a simultaneous write and clears preloaded data.
    we = 1'b1; addr_a = 4'd5; wd = 32'hDEADBEEF; tick();
    we = 1'b0; addr_b = 4'd5; #1;
    check("preload_r5", data_b, 32'hDEADBEEF);
    rst_n = 1'b0; we = 1'b1; addr_a = 4'd5; wd = 32'h12345678; tick();
    rst_n = 1'b1; we = 1'b0; addr_a = 4'd5; addr_b = 4'd5; #1;
    check("rst_prio_a", data_a, 32'h0);
    check("rst_prio_b", data_b, 32'h0);

    // Directed vectors: drive, clock, then read back with writes disabled.
    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; addr_a = vecs[i].a; addr_b = vecs[i].b; wd = vecs[i].w;
      tick();
      we = 1'b0; #1;
      check($sformatf("vec%0d_a", i), data_a, vecs[i].ea);
      check($sformatf("vec%0d_b", i), data_b, vecs[i].eb);
    end

    // Write disabled for three edges.
    we = 1'b0; addr_a = 4'd7; addr_b = 4'd7; wd = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) tick();
    check("wr_dis_r7", data_a, 32'h0);

    // Fill and full independent sweep.
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; addr_a = 4'(i); wd = 32'(i) * 32'h01010101; tick();
    end
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        addr_a = 4'(i); addr_b = 4'(j); #1;
        check($sformatf("sweep_a%0d", i), data_a,
              (ZR != 0 && i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
        check($sformatf("sweep_b%0d", j), data_b,
              (ZR != 0 && j == 0) ? 32'h0 : 32'(j) * 32'h01010101);
      end
    end

    // Same-cycle read of the register being written.
    we = 1'b1; addr_a = 4'd9; wd = 32'h11; tick();
    addr_b = 4'd9; wd = 32'h22; #1;
    check("rw_same_a_pre", data_a, BYP ? 32'h22 : 32'h11);
    check("rw_same_b_pre", data_b, BYP ? 32'h22 : 32'h11);
    tick();
    we = 1'b0; #1;
    check("rw_same_a_post", data_a, 32'h22);
    check("rw_same_b_post", data_b, 32'h22);

    // Randomized run against the model, with occasional reset.
    for (int c = 0; c < 400; c++) begin
      rst_n  = ($urandom_range(0, 31) != 0);
      we     = $urandom_range(0, 1) == 1;
      addr_a = 4'($urandom_range(0, 15));
      addr_b = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom_range(0, 15));
      wd     = $urandom;
      #1;
      check("rand_a", data_a, exp_rd(addr_a));
      check("rand_b", data_b, exp_rd(addr_b));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
